// File: rtl/sqrt_ctrl_if.sv
// Handshake and datapath-control bundle between the square-root controller
// and its surroundings (requester plus iterative datapath).
// The slave view belongs to the controller; the master view belongs to
// whoever issues requests and hosts the datapath.
interface sqrt_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ITER_WIDTH = 8
);
  logic                  start_i;
  logic [DATA_WIDTH-1:0] valor_i;
  logic                  N_i;
  logic                  ready_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;
  logic [ITER_WIDTH-1:0] iter_o;
  logic [DATA_WIDTH-1:0] valor_o;
  logic                  boot_o;
  logic                  wr_square_o;
  logic                  wr_root_o;
  logic                  muxes_o;

  modport master (
    output start_i, valor_i, N_i,
    input  ready_o, busy_o, done_o, err_o, iter_o, valor_o,
    input  boot_o, wr_square_o, wr_root_o, muxes_o
  );

  modport slave (
    input  start_i, valor_i, N_i,
    output ready_o, busy_o, done_o, err_o, iter_o, valor_o,
    output boot_o, wr_square_o, wr_root_o, muxes_o
  );
endinterface

// File: rtl/sqrt_ctrl.sv
// Moore controller sequencing an iterative integer square-root datapath:
// IDLE -> BOOT -> (CHECK -> UPDATE)* -> CHECK -> DONE -> IDLE.
// All outputs come straight from flops; the decoded control word is
// registered from the next-state value so it lines up with the state
// register while never having a combinational path from any input.
module sqrt_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ITER_WIDTH = 8,
  parameter int MAX_ITER   = 255
) (
  input  logic       clk,
  input  logic       rst,
  sqrt_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BOOT   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_UPDATE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef struct packed {
    logic ready;
    logic busy;
    logic done;
    logic boot;
    logic wr_square;
    logic wr_root;
    logic muxes;
  } ctrl_t;

  localparam logic [ITER_WIDTH-1:0] MAX_ITER_C = ITER_WIDTH'(MAX_ITER);
  localparam logic [ITER_WIDTH-1:0] ITER_ONE   = {{(ITER_WIDTH-1){1'b0}}, 1'b1};
  localparam ctrl_t CTRL_IDLE = '{ready: 1'b1, busy: 1'b0, done: 1'b0, boot: 1'b0,
                                  wr_square: 1'b0, wr_root: 1'b0, muxes: 1'b0};

  // Control word seen by the datapath while the FSM sits in a given state.
  function automatic ctrl_t ctrl_decode(input state_t st);
    ctrl_t c;
    c = '{ready: 1'b0, busy: 1'b1, done: 1'b0, boot: 1'b0,
          wr_square: 1'b0, wr_root: 1'b0, muxes: 1'b0};
    case (st)
      ST_IDLE:   c = CTRL_IDLE;
      ST_BOOT:   begin c.boot = 1'b1; c.wr_square = 1'b1; c.wr_root = 1'b1; end
      ST_CHECK:  c.muxes = 1'b1;
      ST_UPDATE: begin c.wr_square = 1'b1; c.wr_root = 1'b1; end
      ST_DONE:   c.done = 1'b1;
      default:   c = CTRL_IDLE;
    endcase
    return c;
  endfunction

  state_t                state_r, state_s;
  logic [DATA_WIDTH-1:0] valor_r, valor_s;
  logic [ITER_WIDTH-1:0] iter_r,  iter_s;
  logic                  err_r,   err_s;
  ctrl_t                 ctrl_r;

  // Next-state, operand capture, iteration count and error flag.
  always_comb begin
    state_s = state_r;
    valor_s = valor_r;
    iter_s  = iter_r;
    err_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start_i) begin
          valor_s = bus.valor_i;
          iter_s  = {ITER_WIDTH{1'b0}};
          err_s   = 1'b0;
          state_s = ST_BOOT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BOOT: state_s = ST_CHECK;
      ST_CHECK: begin
        // A negative difference means the root is found; it takes priority
        // over the iteration limit so a last-step success is not an error.
        if (bus.N_i) begin
          state_s = ST_DONE;
        end else if (iter_r == MAX_ITER_C) begin
          err_s   = 1'b1;
          state_s = ST_DONE;
        end else begin
          state_s = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        // CHECK never enters UPDATE at the limit, so the hold branch only
        // guards against wrap if the state register is ever upset.
        if (iter_r != MAX_ITER_C) begin
          iter_s = iter_r + ITER_ONE;
        end else begin
          iter_s = iter_r;
        end
        state_s = ST_CHECK;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, operand, counter, error and registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      valor_r <= {DATA_WIDTH{1'b0}};
      iter_r  <= {ITER_WIDTH{1'b0}};
      err_r   <= 1'b0;
      ctrl_r  <= CTRL_IDLE;
    end else begin
      state_r <= state_s;
      valor_r <= valor_s;
      iter_r  <= iter_s;
      err_r   <= err_s;
      ctrl_r  <= ctrl_decode(state_s);
    end
  end

  assign bus.ready_o     = ctrl_r.ready;
  assign bus.busy_o      = ctrl_r.busy;
  assign bus.done_o      = ctrl_r.done;
  assign bus.boot_o      = ctrl_r.boot;
  assign bus.wr_square_o = ctrl_r.wr_square;
  assign bus.wr_root_o   = ctrl_r.wr_root;
  assign bus.muxes_o     = ctrl_r.muxes;
  assign bus.err_o       = err_r;
  assign bus.iter_o      = iter_r;
  assign bus.valor_o     = valor_r;

endmodule
